// File: rtl/program_memory_loader.sv
// Byte-stream program loader: assembles little-endian words from a valid/ready byte
// stream, writes them into instruction RAM from TEXT_BASE and verifies an XOR checksum.
module program_memory_loader #(
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            ByteIn,
  input  logic                  ByteValid,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [DATA_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  CpuHold,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error,
  output logic [15:0]           WordCount
);

  localparam int unsigned LEN_W = 16;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEMORY_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_c;
  logic [1:0]       lane;
  logic [23:0]      lane_buf;
  logic [7:0]       checksum;

  logic accept_c;
  logic load_start_c;
  logic word_done_c;
  logic last_word_c;
  logic streaming_next_c;

  assign accept_c     = ByteValid && ByteReady;
  assign load_start_c = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign word_done_c  = accept_c && (state == S_DATA) && (lane == 2'd3);
  assign last_word_c  = (WordCount + 16'd1) == len;
  assign len_c        = {ByteIn, len[7:0]};

  // Next-state decode
  always_comb begin
    state_next       = state;
    streaming_next_c = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept_c) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept_c) begin
          if (len_c > MAX_LEN)          state_next = S_ERROR;
          else if (len_c == 16'd0)      state_next = S_CHECK;
          else                          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done_c && last_word_c) state_next = S_CHECK;
      end
      S_CHECK: begin
        if (accept_c) state_next = (ByteIn == checksum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
    streaming_next_c = (state_next == S_LEN_LO) || (state_next == S_LEN_HI) ||
                       (state_next == S_DATA)   || (state_next == S_CHECK);
  end

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      ByteReady    <= 1'b0;
      Busy         <= 1'b0;
      CpuHold      <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
      WordCount    <= '0;
      len          <= '0;
      lane         <= '0;
      lane_buf     <= '0;
      checksum     <= '0;
    end else begin
      state       <= state_next;
      ByteReady   <= streaming_next_c;
      Busy        <= streaming_next_c;
      CpuHold     <= streaming_next_c || (state_next == S_ERROR);
      Done        <= (state_next == S_DONE);
      Error       <= (state_next == S_ERROR);
      WriteEnable <= word_done_c;

      if (load_start_c) begin
        WordCount <= '0;
        len       <= '0;
        lane      <= '0;
        lane_buf  <= '0;
        checksum  <= '0;
      end

      if (accept_c && (state == S_LEN_LO)) len[7:0]  <= ByteIn;
      if (accept_c && (state == S_LEN_HI)) len[15:8] <= ByteIn;

      // Lanes 0..2 shift in from the top so the word reads {lane3, lane2, lane1, lane0}
      if (accept_c && (state == S_DATA)) begin
        checksum <= checksum ^ ByteIn;
        lane     <= lane + 2'd1;
        lane_buf <= {ByteIn, lane_buf[23:8]};
      end

      if (word_done_c) begin
        WriteData    <= DATA_WIDTH'({ByteIn, lane_buf});
        WriteAddress <= TEXT_BASE + (DATA_WIDTH'(WordCount) << 2);
        WordCount    <= WordCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader: good/bad loads, length bounds, stalls and reset.
module tb_program_memory_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WriteEnable;
  logic [31:0] WriteAddress;
  logic [31:0] WriteData;
  logic        CpuHold;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [15:0] WordCount;

  int total;
  int bad;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  stim[16];

  program_memory_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ByteIn       (ByteIn),
    .ByteValid    (ByteValid),
    .ByteReady    (ByteReady),
    .WriteEnable  (WriteEnable),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .CpuHold      (CpuHold),
    .Busy         (Busy),
    .Done         (Done),
    .Error        (Error),
    .WordCount    (WordCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each write strobe is high for one full cycle, so one negedge sample per pulse
  always @(negedge clk) begin
    if (reset && WriteEnable) begin
      wa_q.push_back(WriteAddress);
      wd_q.push_back(WriteData);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    while (!ByteReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ByteReady) chk("byte_timeout", 32'(ByteReady), 32'd1);
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_good_stim(input logic [7:0] last);
    stim[0] = 8'h02; stim[1] = 8'h00;
    stim[2] = 8'h78; stim[3] = 8'h56; stim[4] = 8'h34; stim[5] = 8'h12;
    stim[6] = 8'hEF; stim[7] = 8'hBE; stim[8] = 8'hAD; stim[9] = 8'hDE;
    stim[10] = last;
  endtask

  task automatic send_stim(input int len, input int gap, input bit stray);
    for (int i = 0; i < len; i++) begin
      send_byte(stim[i]);
      if (gap > 0 && i < len - 1) begin
        for (int g = 0; g < gap; g++) begin
          start = (stray && i == 5 && g == 1);
          @(negedge clk);
        end
        start = 1'b0;
      end
    end
  endtask

  task automatic check_two_writes(input string tag);
    logic [31:0] a0, a1, d0, d1;
    a0 = (wa_q.size() > 0) ? wa_q[0] : 32'hFFFF_FFFF;
    d0 = (wd_q.size() > 0) ? wd_q[0] : 32'hFFFF_FFFF;
    a1 = (wa_q.size() > 1) ? wa_q[1] : 32'hFFFF_FFFF;
    d1 = (wd_q.size() > 1) ? wd_q[1] : 32'hFFFF_FFFF;
    chk({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
    chk({tag, "_a0"}, a0, 32'h0040_0000);
    chk({tag, "_d0"}, d0, 32'h1234_5678);
    chk({tag, "_a1"}, a1, 32'h0040_0004);
    chk({tag, "_d1"}, d1, 32'hDEAD_BEEF);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdy"},  32'(ByteReady),   32'd0);
    chk({tag, "_we"},   32'(WriteEnable), 32'd0);
    chk({tag, "_hold"}, 32'(CpuHold),     32'd0);
    chk({tag, "_busy"}, 32'(Busy),        32'd0);
    chk({tag, "_done"}, 32'(Done),        32'd0);
    chk({tag, "_err"},  32'(Error),       32'd0);
    chk({tag, "_wc"},   32'(WordCount),   32'd0);
  endtask

  task automatic check_done(input string tag, input logic [15:0] wc);
    chk({tag, "_done"}, 32'(Done),      32'd1);
    chk({tag, "_err"},  32'(Error),     32'd0);
    chk({tag, "_hold"}, 32'(CpuHold),   32'd0);
    chk({tag, "_busy"}, 32'(Busy),      32'd0);
    chk({tag, "_rdy"},  32'(ByteReady), 32'd0);
    chk({tag, "_wc"},   32'(WordCount), 32'(wc));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    start = 1'b0;
    ByteIn = 8'h55;
    ByteValid = 1'b1;

    // Reset with a valid byte presented
    repeat (2) @(negedge clk);
    check_idle("rst");
    chk("rst_wa", WriteAddress, 32'h0);
    chk("rst_wd", WriteData, 32'h0);
    chk("rst_nwr", 32'(wa_q.size()), 32'd0);
    ByteValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_idle("idle");

    // Good load
    pulse_start();
    chk("ld_busy", 32'(Busy), 32'd1);
    chk("ld_hold", 32'(CpuHold), 32'd1);
    chk("ld_rdy", 32'(ByteReady), 32'd1);
    load_good_stim(8'h2A);
    send_stim(11, 0, 1'b0);
    check_done("good", 16'd2);
    check_two_writes("good");
    @(negedge clk);
    chk("hold_wa", WriteAddress, 32'h0040_0004);
    chk("hold_wd", WriteData, 32'hDEAD_BEEF);
    chk("hold_we", 32'(WriteEnable), 32'd0);

    // Bad checksum
    wa_q.delete(); wd_q.delete();
    pulse_start();
    chk("bad_donecl", 32'(Done), 32'd0);
    load_good_stim(8'h2B);
    send_stim(11, 0, 1'b0);
    check_two_writes("bad");
    chk("bad_err", 32'(Error), 32'd1);
    chk("bad_hold", 32'(CpuHold), 32'd1);
    chk("bad_done", 32'(Done), 32'd0);
    chk("bad_busy", 32'(Busy), 32'd0);
    chk("bad_rdy", 32'(ByteReady), 32'd0);
    chk("bad_wc", 32'(WordCount), 32'd2);
    repeat (2) @(negedge clk);
    chk("bad_errhold", 32'(Error), 32'd1);
    pulse_start();
    chk("bad_errcl", 32'(Error), 32'd0);
    chk("bad_rebusy", 32'(Busy), 32'd1);

    // Oversize length, continuing the load just started
    wa_q.delete(); wd_q.delete();
    send_byte(8'h21);
    send_byte(8'h00);
    chk("big_err", 32'(Error), 32'd1);
    chk("big_rdy", 32'(ByteReady), 32'd0);
    chk("big_hold", 32'(CpuHold), 32'd1);
    chk("big_busy", 32'(Busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("big_nwr", 32'(wa_q.size()), 32'd0);

    // Empty image
    pulse_start();
    stim[0] = 8'h00; stim[1] = 8'h00; stim[2] = 8'h00;
    send_stim(3, 0, 1'b0);
    check_done("zero", 16'd0);
    repeat (2) @(negedge clk);
    chk("zero_nwr", 32'(wa_q.size()), 32'd0);

    // Stalled stream with a stray start mid-load
    pulse_start();
    load_good_stim(8'h2A);
    send_stim(11, 3, 1'b1);
    check_done("stall", 16'd2);
    check_two_writes("stall");

    // Reset in the middle of the first word
    wa_q.delete(); wd_q.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(stim[i]);
    reset = 1'b0;
    @(negedge clk);
    check_idle("mrst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_nwr", 32'(wa_q.size()), 32'd0);
    chk("mrst_rdy", 32'(ByteReady), 32'd0);
    pulse_start();
    send_stim(11, 0, 1'b0);
    check_done("after", 16'd2);
    check_two_writes("after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
